bus_arbiter: RTL and testbench

- Two-requester arbiter sharing a single-port resource (e.g. unified memory port between fetch unit A and load/store unit B).
- Drives the select of a SIZE-wide 2:1 mux (SEL=0 passes A, SEL=1 passes B) and returns per-requester grants.
- Level request/grant handshake, round-robin priority, bounded hold time with preemption, one-cycle dead cycle on every owner change.

---
 rtl/bus_arbiter.sv | 126 ++++++++++++
 tb/tb_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter for a shared single-port resource, with a
// bounded hold time, preemption and one dead cycle on every ownership change.
module bus_arbiter #(
    parameter  int MAX_HOLD = 8,
    localparam int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic REQ_A,
    input  logic REQ_B,
    output logic GNT_A,
    output logic GNT_B,
    output logic SEL,
    output logic BUSY,
    output logic PREEMPT
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OWN_A   = 2'd1;
    localparam logic [1:0] ST_OWN_B   = 2'd2;
    localparam logic [1:0] ST_HANDOFF = 2'd3;

    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD - 1);

    logic [1:0]    r_state;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic          r_gnt_a;
    logic          r_gnt_b;
    logic          r_sel;
    logic          r_busy;
    logic          r_preempt;

    logic [1:0]    w_next;
    logic          w_last_next;
    logic          w_preempt;
    logic          w_hold_hit;

    // r_last remembers the most recent owner (1 = B); it breaks ties in IDLE
    // and tells HANDOFF who the outgoing owner was.
    assign w_hold_hit = (r_cnt == HOLD_LIMIT);

    always_comb begin
        w_next      = r_state;
        w_last_next = r_last;
        w_preempt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (REQ_A && REQ_B) begin
                    w_next = r_last ? ST_OWN_A : ST_OWN_B;
                end else if (REQ_A) begin
                    w_next = ST_OWN_A;
                end else if (REQ_B) begin
                    w_next = ST_OWN_B;
                end
            end
            ST_OWN_A: begin
                if (!REQ_A) begin
                    w_next      = REQ_B ? ST_HANDOFF : ST_IDLE;
                    w_last_next = 1'b0;
                end else if (REQ_B && w_hold_hit) begin
                    w_next      = ST_HANDOFF;
                    w_last_next = 1'b0;
                    w_preempt   = 1'b1;
                end
            end
            ST_OWN_B: begin
                if (!REQ_B) begin
                    w_next      = REQ_A ? ST_HANDOFF : ST_IDLE;
                    w_last_next = 1'b1;
                end else if (REQ_A && w_hold_hit) begin
                    w_next      = ST_HANDOFF;
                    w_last_next = 1'b1;
                    w_preempt   = 1'b1;
                end
            end
            default: begin
                // The waiting side gets first claim; the outgoing owner may
                // resume only if nobody else wants the resource.
                if (r_last) begin
                    w_next = REQ_A ? ST_OWN_A : (REQ_B ? ST_OWN_B : ST_IDLE);
                end else begin
                    w_next = REQ_B ? ST_OWN_B : (REQ_A ? ST_OWN_A : ST_IDLE);
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so every output is a flop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_gnt_a   <= 1'b0;
            r_gnt_b   <= 1'b0;
            r_sel     <= 1'b0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_last    <= w_last_next;
            r_preempt <= w_preempt;
            r_gnt_a   <= (w_next == ST_OWN_A);
            r_gnt_b   <= (w_next == ST_OWN_B);
            r_busy    <= (w_next != ST_IDLE);
            if (w_next == ST_OWN_A) begin
                r_sel <= 1'b0;
            end else if (w_next == ST_OWN_B) begin
                r_sel <= 1'b1;
            end
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (((r_state == ST_OWN_A) || (r_state == ST_OWN_B)) && !w_hold_hit) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign GNT_A   = r_gnt_a;
    assign GNT_B   = r_gnt_b;
    assign SEL     = r_sel;
    assign BUSY    = r_busy;
    assign PREEMPT = r_preempt;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (MAX_HOLD 8 and 1) share the same
// requests and are compared every cycle against a turn-based arbitration model.
module tb_bus_arbiter;

    logic clk;
    logic rstN;
    logic reqA;
    logic reqB;
    logic [1:0] gntA;
    logic [1:0] gntB;
    logic [1:0] sel;
    logic [1:0] busy;
    logic [1:0] pre;

    int nChecks = 0;
    int nErrors = 0;
    bit checkEn = 0;

    // Model: who owns the resource (-1 none, 0 A, 1 B), whether this is the
    // dead cycle after a turn, how many cycles the current turn has lasted.
    int maxHold[2] = '{8, 1};
    int mOwner[2]  = '{-1, -1};
    bit mDead[2]   = '{0, 0};
    int mHeld[2]   = '{0, 0};
    int mLast[2]   = '{1, 1};
    bit mSel[2]    = '{0, 0};
    bit mPre[2]    = '{0, 0};

    bus_arbiter #(.MAX_HOLD(8)) dut0 (
        .CLK(clk), .RST_N(rstN), .REQ_A(reqA), .REQ_B(reqB),
        .GNT_A(gntA[0]), .GNT_B(gntB[0]), .SEL(sel[0]), .BUSY(busy[0]), .PREEMPT(pre[0])
    );

    bus_arbiter #(.MAX_HOLD(1)) dut1 (
        .CLK(clk), .RST_N(rstN), .REQ_A(reqA), .REQ_B(reqB),
        .GNT_A(gntA[1]), .GNT_B(gntB[1]), .SEL(sel[1]), .BUSY(busy[1]), .PREEMPT(pre[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic modelReset(input int i);
        mOwner[i] = -1;
        mDead[i]  = 1'b0;
        mHeld[i]  = 0;
        mLast[i]  = 1;
        mSel[i]   = 1'b0;
        mPre[i]   = 1'b0;
    endtask

    task automatic modelStep(input int i, input bit ra, input bit rb);
        bit req[2];
        int o;
        req[0] = ra;
        req[1] = rb;
        mPre[i] = 1'b0;
        if (mDead[i]) begin
            mDead[i] = 1'b0;
            if (req[1 - mLast[i]]) mOwner[i] = 1 - mLast[i];
            else if (req[mLast[i]]) mOwner[i] = mLast[i];
            else mOwner[i] = -1;
            mHeld[i] = 1;
        end else if (mOwner[i] < 0) begin
            if (ra && rb) mOwner[i] = 1 - mLast[i];
            else if (ra) mOwner[i] = 0;
            else if (rb) mOwner[i] = 1;
            mHeld[i] = 1;
        end else begin
            o = mOwner[i];
            if (!req[o]) begin
                mLast[i]  = o;
                mOwner[i] = -1;
                mDead[i]  = req[1 - o];
            end else if (req[1 - o] && mHeld[i] >= maxHold[i]) begin
                mLast[i]  = o;
                mOwner[i] = -1;
                mDead[i]  = 1'b1;
                mPre[i]   = 1'b1;
            end else begin
                mHeld[i]++;
            end
        end
        if (mOwner[i] >= 0) mSel[i] = (mOwner[i] == 1);
    endtask

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < 2; i++) modelReset(i);
        end else begin
            for (int i = 0; i < 2; i++) modelStep(i, reqA, reqB);
        end
    end

    task automatic checkOutput(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("gnt_a[%0d]", i), gntA[i], mOwner[i] == 0);
                checkOutput($sformatf("gnt_b[%0d]", i), gntB[i], mOwner[i] == 1);
                checkOutput($sformatf("sel[%0d]", i), sel[i], mSel[i]);
                checkOutput($sformatf("busy[%0d]", i), busy[i], (mOwner[i] >= 0) || mDead[i]);
                checkOutput($sformatf("preempt[%0d]", i), pre[i], mPre[i]);
                checkOutput($sformatf("mutex[%0d]", i), gntA[i] & gntB[i], 1'b0);
            end
        end
    end

    task automatic applyStimulus(input bit a, input bit b);
        reqA = a;
        reqB = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cnt;
        int preCnt;
        bit ra;
        bit rb;
        reqA = 1'b0;
        reqB = 1'b0;
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        checkEn = 1'b1;
        checkOutput("reset gnt_a", gntA[0], 1'b0);
        checkOutput("reset gnt_b", gntB[0], 1'b0);
        checkOutput("reset sel", sel[0], 1'b0);
        checkOutput("reset busy", busy[0], 1'b0);
        checkOutput("reset preempt", pre[0], 1'b0);

        // Lone requester B for three cycles.
        cnt = 0;
        repeat (3) begin
            applyStimulus(0, 1);
            cnt += int'(gntB[0]);
        end
        applyStimulus(0, 0);
        checkOutput("single b grant count is 3", cnt == 3, 1'b1);
        checkOutput("single b gnt_b after release", gntB[0], 1'b0);
        checkOutput("single b sel stays 1", sel[0], 1'b1);
        checkOutput("single b busy idle", busy[0], 1'b0);

        // Give A a short turn so the last owner is A, then tie.
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(1, 1);
        checkOutput("tie gnt_b first", gntB[0], 1'b1);
        checkOutput("tie gnt_a low", gntA[0], 1'b0);
        checkOutput("tie sel b", sel[0], 1'b1);
        checkOutput("tie gnt_b first hold1", gntB[1], 1'b1);
        applyStimulus(1, 1);
        applyStimulus(1, 0);
        checkOutput("handoff gnt_a", gntA[0], 1'b0);
        checkOutput("handoff gnt_b", gntB[0], 1'b0);
        checkOutput("handoff busy", busy[0], 1'b1);
        checkOutput("handoff sel holds", sel[0], 1'b1);
        applyStimulus(1, 0);
        checkOutput("after handoff gnt_a", gntA[0], 1'b1);
        checkOutput("after handoff sel a", sel[0], 1'b0);

        // A owns, B joins: A must be cut off after exactly 8 grant cycles.
        cnt = 1;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 1);
            if (!gntA[0]) break;
            cnt++;
        end
        checkOutput("preempt a hold is 8", cnt == 8, 1'b1);
        checkOutput("preempt pulse", pre[0], 1'b1);
        checkOutput("preempt dead busy", busy[0], 1'b1);
        applyStimulus(1, 1);
        checkOutput("after preempt gnt_b", gntB[0], 1'b1);
        checkOutput("preempt pulse single", pre[0], 1'b0);
        cnt = 1;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 1);
            if (!gntB[0]) break;
            cnt++;
        end
        checkOutput("preempt b hold is 8", cnt == 8, 1'b1);
        applyStimulus(1, 1);
        checkOutput("a requeued", gntA[0], 1'b1);

        // A preempted again; B gives up during the dead cycle.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 1);
            if (pre[0]) break;
        end
        checkOutput("drop in handoff dead cycle", gntA[0], 1'b0);
        applyStimulus(1, 0);
        checkOutput("drop in handoff a regranted", gntA[0], 1'b1);

        // Uncontended A keeps the grant indefinitely.
        cnt = 0;
        preCnt = 0;
        repeat (50) begin
            applyStimulus(1, 0);
            cnt += int'(gntA[0]);
            preCnt += int'(pre[0]);
        end
        checkOutput("no contention 50 grants", cnt == 50, 1'b1);
        checkOutput("no contention no preempt", preCnt == 0, 1'b1);

        // Asynchronous reset in the middle of A's grant.
        #3 rstN = 1'b0;
        #1;
        checkOutput("async reset gnt_a", gntA[0], 1'b0);
        checkOutput("async reset busy", busy[0], 1'b0);
        checkOutput("async reset sel", sel[0], 1'b0);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        applyStimulus(1, 1);
        checkOutput("post reset a first", gntA[0], 1'b1);
        checkOutput("post reset a first hold1", gntA[1], 1'b1);
        applyStimulus(0, 0);
        applyStimulus(0, 0);

        // Random requests, mostly held for a while so preemption happens.
        ra = 1'b0;
        rb = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (ra) ra = ($urandom_range(0, 5) != 0);
            else    ra = ($urandom_range(0, 3) == 0);
            if (rb) rb = ($urandom_range(0, 5) != 0);
            else    rb = ($urandom_range(0, 3) == 0);
            applyStimulus(ra, rb);
        end
        applyStimulus(0, 0);
        @(negedge clk);
        #1 checkEn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
